// File: rtl/multi_div_array.sv
// N-channel array of iterative restoring dividers, each fed by its own instruction FIFO.
// Latency: pop to res_valid is DW+1 enabled edges (1 edge for a zero divisor); push visible the next cycle.
// Backpressure: a push to a full FIFO is dropped and flagged in sticky ovf; core_en=0 freezes a core.
// Optional feature: define MULTI_DIV_RR_EN for round-robin push routing (chan field ignored).

// Generic synchronous FIFO; the caller guarantees no push when full (unless popping) and no pop when empty.
module mdiv_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage array, written at the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count is unchanged on simultaneous push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

module multi_div_array #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(NCH),
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = CW + 2*DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IW-1:0]           instruction,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [NCH-1:0]          core_en,
  output logic [NCH*(AW+1)-1:0]   fifo_count,
  output logic [NCH-1:0]          data_empty,
  output logic [NCH-1:0]          data_full,
  output logic [NCH-1:0]          ovf,
  output logic [NCH*DW-1:0]       quot,
  output logic [NCH*DW-1:0]       rem,
  output logic [NCH-1:0]          res_valid,
  output logic [NCH-1:0]          div_zero
);
  localparam int SW = $clog2(DW+1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] ovf_set;

`ifdef MULTI_DIV_RR_EN
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_tgt;
  logic [CW-1:0] rr_idx;
  logic          rr_hit;

  // Pick the first channel at or after the pointer that can accept a word this cycle.
  always_comb begin
    rr_tgt  = rr_ptr;
    rr_idx  = rr_ptr;
    rr_hit  = 1'b0;
    push    = '0;
    ovf_set = '0;
    for (int i = 0; i < NCH; i++) begin
      rr_idx = rr_ptr + CW'(i);
      if (!rr_hit && (!data_full[rr_idx] || pop[rr_idx])) begin
        rr_hit = 1'b1;
        rr_tgt = rr_idx;
      end
    end
    if (wr_en) begin
      if (rr_hit) push[rr_tgt]    = 1'b1;
      else        ovf_set[rr_ptr] = 1'b1;
    end
  end

  // Pointer moves past the channel that took the last accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rr_ptr <= '0;
    else if (wr_en && rr_hit) rr_ptr <= rr_tgt + 1'b1;
  end
`else
  logic [CW-1:0] chan;
  assign chan = instruction[IW-1 -: CW];

  // Route by the chan field; a full FIFO accepts only if it pops in the same cycle.
  always_comb begin
    push    = '0;
    ovf_set = '0;
    if (wr_en) begin
      if (!data_full[chan] || pop[chan]) push[chan]    = 1'b1;
      else                               ovf_set[chan] = 1'b1;
    end
  end
`endif

  // Sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= '0;
    else     ovf <= ovf | ovf_set;
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      st_t             state;
      st_t             state_nx;
      logic [2*DW-1:0] head;
      logic [DW:0]     prem;
      logic [DW-1:0]   qacc;
      logic [DW-1:0]   dvs;
      logic [SW-1:0]   step;
      logic [DW:0]     sh;
      logic            ge;
      logic            do_step;
      logic            finish;
      logic            leave_done;
      logic [DW-1:0]   q_r;
      logic [DW-1:0]   r_r;
      logic            rv_r;
      logic            dz_r;

      mdiv_fifo #(.WIDTH(2*DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[g]),
        .pop   (pop[g]),
        .din   (instruction[2*DW-1:0]),
        .dout  (head),
        .count (fifo_count[g*(AW+1) +: AW+1]),
        .empty (data_empty[g]),
        .full  (data_full[g])
      );

      // A core takes a new word when idle, or on the edge that leaves DONE.
      assign pop[g] = core_en[g] && rd_en && !data_empty[g] && (state == IDLE || state == DONE);

      // Core state register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
      end

      // Next state; a disabled core holds its state.
      always_comb begin
        state_nx = state;
        if (core_en[g]) begin
          case (state)
            IDLE:    if (pop[g]) state_nx = BUSY;
            BUSY:    if (dvs == '0 || step == SW'(DW)) state_nx = DONE;
            DONE:    state_nx = pop[g] ? BUSY : IDLE;
            default: state_nx = IDLE;
          endcase
        end
      end

      // Per-state control strobes.
      always_comb begin
        do_step    = 1'b0;
        finish     = 1'b0;
        leave_done = 1'b0;
        if (core_en[g]) begin
          case (state)
            BUSY: begin
              if (dvs == '0 || step == SW'(DW)) finish  = 1'b1;
              else                              do_step = 1'b1;
            end
            DONE:    leave_done = 1'b1;
            default: ;
          endcase
        end
      end

      // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
      assign sh = {prem[DW-1:0], qacc[DW-1]};
      assign ge = (sh >= {1'b0, dvs});

      // Working registers; qacc starts as the dividend and fills with quotient bits MSB-first.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prem <= '0;
          qacc <= '0;
          dvs  <= '0;
          step <= '0;
        end else if (pop[g]) begin
          qacc <= head[2*DW-1:DW];
          dvs  <= head[DW-1:0];
          prem <= '0;
          step <= '0;
        end else if (do_step) begin
          prem <= ge ? (sh - {1'b0, dvs}) : sh;
          qacc <= {qacc[DW-2:0], ge};
          step <= step + 1'b1;
        end
      end

      // Result registers; quot/rem/div_zero hold until the next result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_r  <= '0;
          r_r  <= '0;
          rv_r <= 1'b0;
          dz_r <= 1'b0;
        end else if (finish) begin
          rv_r <= 1'b1;
          if (dvs == '0) begin
            q_r  <= '1;
            r_r  <= qacc;
            dz_r <= 1'b1;
          end else begin
            q_r  <= qacc;
            r_r  <= prem[DW-1:0];
            dz_r <= 1'b0;
          end
        end else if (leave_done) begin
          rv_r <= 1'b0;
        end
      end

      assign quot[g*DW +: DW] = q_r;
      assign rem[g*DW +: DW]  = r_r;
      assign res_valid[g]     = rv_r;
      assign div_zero[g]      = dz_r;
    end
  endgenerate
endmodule

// File: tb/tb_multi_div_array.sv
// Self-checking bench for multi_div_array (NCH=4, DW=8, DEPTH=8, chan-field routing).
module tb_multi_div_array;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEPTH = 8;
  localparam int AW  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [17:0]        instruction;
  logic               wr_en;
  logic               rd_en;
  logic [NCH-1:0]     core_en;
  logic [NCH*(AW+1)-1:0] fifo_count;
  logic [NCH-1:0]     data_empty;
  logic [NCH-1:0]     data_full;
  logic [NCH-1:0]     ovf;
  logic [NCH*DW-1:0]  quot;
  logic [NCH*DW-1:0]  rem;
  logic [NCH-1:0]     res_valid;
  logic [NCH-1:0]     div_zero;

  int checks = 0;
  int errors = 0;

  multi_div_array #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .core_en     (core_en),
    .fifo_count  (fifo_count),
    .data_empty  (data_empty),
    .data_full   (data_full),
    .ovf         (ovf),
    .quot        (quot),
    .rem         (rem),
    .res_valid   (res_valid),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : a / b;
  endfunction

  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : a % b;
  endfunction

  // Push one division into an idle array and follow it to its result.
  task automatic run_one(input int ch, input logic [7:0] a, input logic [7:0] b);
    int lat;
    int exp_lat;
    logic [7:0] oq;
    logic [7:0] orem;
    logic odz;
    exp_lat = (b == 8'd0) ? 2 : DW + 2;
    oq = '0; orem = '0; odz = 1'b0;
    instruction = {2'(ch), a, b};
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("push_count", 64'(fifo_count[ch*(AW+1) +: AW+1]), 64'd1);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (res_valid[ch]) begin
        lat  = n;
        oq   = quot[ch*DW +: DW];
        orem = rem[ch*DW +: DW];
        odz  = div_zero[ch];
        break;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("quot", 64'(oq), 64'(ref_q(a, b)));
    check("rem", 64'(orem), 64'(ref_r(a, b)));
    check("div_zero", 64'(odz), 64'(b == 8'd0));
    step();
    check("valid_pulse", 64'(res_valid[ch]), 64'd0);
  endtask

  initial begin
    logic [15:0] expq[$];
    logic [15:0] ent;
    logic [7:0] a;
    logic [7:0] b;
    int got;
    int first3;
    int first0;
    logic [7:0] q3, r3, q0, r0, a0, b0;
    logic stray;

    // Reset state
    rst = 1'b1; instruction = '0; wr_en = 1'b0; rd_en = 1'b1; core_en = 4'hF;
    step(); step();
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_empty", 64'(data_empty), 64'hF);
    check("rst_full", 64'(data_full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_quot", 64'(quot), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    #2 rst = 1'b0;
    step();

    // Directed single division and divide by zero
    run_one(0, 8'd200, 8'd7);
    run_one(1, 8'd45, 8'd0);

    // Randomized divisions on random channels
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_one(int'($urandom_range(0, 3)), a, b);
    end
    run_one(2, 8'd255, 8'd1);
    run_one(3, 8'd3, 8'd255);

    // FIFO fill and overflow on channel 2 with dispatch held off
    rd_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i < DEPTH) expq.push_back({a, b});
      instruction = {2'd2, a, b};
      wr_en = 1'b1;
      step();
      if (i == DEPTH - 1) begin
        check("fill_full", 64'(data_full), 64'b0100);
        check("fill_ovf_clear", 64'(ovf), 64'd0);
      end
    end
    wr_en = 1'b0;
    check("ovf_count", 64'(fifo_count), 64'h0800);
    check("ovf_flag", 64'(ovf), 64'b0100);
    check("ovf_full", 64'(data_full), 64'b0100);
    rd_en = 1'b1;
    got = 0;
    for (int n = 0; n < 150 && got < DEPTH; n++) begin
      step();
      if (res_valid[2]) begin
        ent = expq.pop_front();
        check("drain_quot", 64'(quot[2*DW +: DW]), 64'(ref_q(ent[15:8], ent[7:0])));
        check("drain_rem", 64'(rem[2*DW +: DW]), 64'(ref_r(ent[15:8], ent[7:0])));
        got++;
      end
    end
    check("drain_results", 64'(got), 64'(DEPTH));
    check("drain_empty", 64'(data_empty), 64'hF);
    step(); step();

    // Freeze core 3 for five edges mid-division while core 0 runs alongside
    a0 = 8'($urandom);
    b0 = 8'($urandom_range(1, 255));
    instruction = {2'd3, 8'd255, 8'd16};
    wr_en = 1'b1;
    step();
    instruction = {2'd0, a0, b0};
    step();
    wr_en = 1'b0;
    first3 = -1; first0 = -1;
    q3 = '0; r3 = '0; q0 = '0; r0 = '0;
    for (int n = 2; n <= 40; n++) begin
      core_en = (n >= 4 && n <= 8) ? 4'b0111 : 4'hF;
      step();
      if (res_valid[3] && first3 < 0) begin
        first3 = n; q3 = quot[3*DW +: DW]; r3 = rem[3*DW +: DW];
      end
      if (res_valid[0] && first0 < 0) begin
        first0 = n; q0 = quot[DW-1:0]; r0 = rem[DW-1:0];
      end
    end
    core_en = 4'hF;
    check("freeze_lat3", 64'(first3), 64'd15);
    check("freeze_q3", 64'(q3), 64'd15);
    check("freeze_r3", 64'(r3), 64'd15);
    check("freeze_lat0", 64'(first0), 64'd11);
    check("freeze_q0", 64'(q0), 64'(ref_q(a0, b0)));
    check("freeze_r0", 64'(r0), 64'(ref_r(a0, b0)));

    // Reset with a busy core and three queued entries
    for (int i = 0; i < 4; i++) begin
      instruction = {2'd1, 8'($urandom), 8'($urandom_range(1, 255))};
      wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_count", 64'(fifo_count[1*(AW+1) +: AW+1]), 64'd3);
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_count", 64'(fifo_count), 64'd0);
    check("arst_empty", 64'(data_empty), 64'hF);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_quot", 64'(quot), 64'd0);
    check("arst_rem", 64'(rem), 64'd0);
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_dz", 64'(div_zero), 64'd0);
    step();
    #2 rst = 1'b0;
    stray = 1'b0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (res_valid != '0) stray = 1'b1;
    end
    check("post_rst_no_valid", 64'(stray), 64'd0);
    check("post_rst_count", 64'(fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
